// File: rtl/debug_link_pkg.sv
// Shared definitions for the serial debug link (transmitter and host-side decoder).
package debug_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         NUM_DEBUG_PORTS   = 7;
  localparam int         FRAME_BYTES       = 9;

  // Frame sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef logic [7:0] byte_t;
  typedef logic [NUM_DEBUG_PORTS-1:0][7:0] snap_t;

  // Frame checksum: XOR of all debug bytes (sync byte excluded)
  function automatic byte_t frame_chk(input snap_t s);
    byte_t c;
    c = '0;
    for (int i = 0; i < NUM_DEBUG_PORTS; i++) begin
      c = c ^ s[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be accepted in the last cycle of the
// previous stop bit, so bytes can be streamed with no idle bits between them.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  logic        active;
  logic [15:0] bit_timer;
  logic [3:0]  bit_idx;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]  shadow;

  assign done  = active && (bit_idx == 4'd9) && (bit_timer == BIT_LAST);
  assign ready = !active || done;

  // Bit timing, bit sequencing and the registered line output
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      active    <= 1'b0;
      bit_timer <= '0;
      bit_idx   <= '0;
      tx        <= 1'b1;
    end else if (start && ready) begin
      active    <= 1'b1;
      bit_timer <= '0;
      bit_idx   <= '0;
      tx        <= 1'b0;
    end else if (active) begin
      if (bit_timer == BIT_LAST) begin
        bit_timer <= '0;
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          bit_idx <= '0;
          tx      <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= (bit_idx == 4'd8) ? 1'b1 : shadow[bit_idx[2:0]];
        end
      end else begin
        bit_timer <= bit_timer + 16'd1;
      end
    end
  end

  // Hold the byte being shifted out; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (start && ready) begin
      shadow <= data;
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Debug frame transmitter: snapshots seven debug ports and sends
// SYNC, p1..p7, CHK as a continuous 8N1 stream, followed by an idle gap.
module debug_frame_tx
  import debug_link_pkg::*;
#(
  parameter int    CLKS_PER_BIT     = 434,
  parameter int    FRAME_GAP_CYCLES = 1000,
  parameter byte_t SYNC_BYTE        = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       enable,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int GAP_W = (FRAME_GAP_CYCLES > 0) ? $clog2(FRAME_GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((FRAME_GAP_CYCLES > 0) ? FRAME_GAP_CYCLES - 1 : 0);
  localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

  logic [1:0]       state, state_nxt;
  logic [3:0]       byte_idx;
  logic [GAP_W-1:0] gap_cnt;
  snap_t            ports;
  byte_t            frame_mem [FRAME_BYTES-1];   // p1..p7 then CHK
  logic             ser_start, ser_ready, ser_done;
  byte_t            ser_data;
  logic             last_byte_done;

  assign ports = {debug_port7, debug_port6, debug_port5, debug_port4,
                  debug_port3, debug_port2, debug_port1};

  assign last_byte_done = (state == ST_SEND) && ser_done && (byte_idx == LAST_BYTE);

  // Next state and serializer feed; the next byte is handed over in the
  // last stop-bit cycle so the following start bit has no gap
  always_comb begin
    state_nxt = state;
    ser_start = 1'b0;
    ser_data  = SYNC_BYTE;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_LOAD;
      ST_LOAD: begin
        ser_start = ser_ready;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (ser_done) begin
          if (byte_idx == LAST_BYTE) begin
            state_nxt = (FRAME_GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            ser_start = 1'b1;
            ser_data  = frame_mem[byte_idx[2:0]];
          end
        end
      end
      ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM, byte/gap counters and registered status outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      byte_idx   <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= last_byte_done;
      if (last_byte_done) begin
        byte_idx <= '0;
      end else if ((state == ST_SEND) && ser_done) begin
        byte_idx <= byte_idx + 4'd1;
      end
      if ((state == ST_GAP) && (gap_cnt != GAP_LAST)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // Snapshot of the debug ports and their checksum, taken in LOAD only
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) begin
      for (int i = 0; i < NUM_DEBUG_PORTS; i++) begin
        frame_mem[i] <= ports[i];
      end
      frame_mem[NUM_DEBUG_PORTS] <= frame_chk(ports);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk    (clk),
    .nreset (nreset),
    .start  (ser_start),
    .data   (ser_data),
    .tx     (tx),
    .ready  (ser_ready),
    .done   (ser_done)
  );

endmodule
